// File: rtl/sequence_generator_if.sv
// rtl/sequence_generator_if.sv - word handshake and serial stream bundle for sequence_generator
interface sequence_generator_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4,
    parameter int LEN_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0] data_in;
    logic [LEN_W-1:0] len_in;
    logic [CNT_W-1:0] rep_in;
    logic             valid_in;
    logic             ready_out;
    logic             out;
    logic             out_valid;
    logic             last;

    modport master (
        output data_in, len_in, rep_in, valid_in,
        input  ready_out, out, out_valid, last
    );

    modport slave (
        input  data_in, len_in, rep_in, valid_in,
        output ready_out, out, out_valid, last
    );
endinterface

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - parallel-in/serial-out pattern transmitter, MSB-first with repeats
// Ready is asserted on the final bit so the next word streams out with no gap.
module sequence_generator #(
    parameter int WIDTH    = 16,
    parameter int CNT_W    = 4,
    parameter bit IDLE_BIT = 1'b0,
    parameter int LEN_W    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    sequence_generator_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] idx;
    logic [CNT_W-1:0] rep_r;
    logic             word_done;
    logic             accept;
    logic             ready;
    logic             out_bit;
    logic             out_vld;
    logic             last_bit;

    assign word_done = (state == SHIFT) && (idx == '0) && (rep_r == '0);
    assign accept    = bus.valid_in && ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (word_done && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A new word may load on the same edge that retires the previous one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            len_r <= '0;
            idx   <= '0;
            rep_r <= '0;
        end else if (accept) begin
            shreg <= bus.data_in;
            len_r <= bus.len_in;
            idx   <= bus.len_in;
            rep_r <= bus.rep_in;
        end else if (state == SHIFT) begin
            if (idx != '0) begin
                idx <= idx - LEN_W'(1);
            end else if (rep_r != '0) begin
                rep_r <= rep_r - CNT_W'(1);
                idx   <= len_r;
            end
        end
    end

    always_comb begin
        out_bit  = IDLE_BIT;
        out_vld  = 1'b0;
        last_bit = 1'b0;
        if (state == SHIFT) begin
            out_bit  = shreg[idx];
            out_vld  = 1'b1;
            last_bit = word_done;
        end
        ready = reset && ((state == IDLE) || word_done);
    end

    assign bus.out       = out_bit;
    assign bus.out_valid = out_vld;
    assign bus.last      = last_bit;
    assign bus.ready_out = ready;

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - directed self-checking bench for sequence_generator
module tb_sequence_generator;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    sequence_generator_if #(.WIDTH(16), .CNT_W(4)) bus ();

    sequence_generator #(.WIDTH(16), .CNT_W(4), .IDLE_BIT(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge of the first bit; returns at the falling edge after the last bit.
    task automatic check_stream(input string tag, input logic [63:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_out%0d", tag, i), 32'(bus.out), 32'(exp[n-1-i]));
            chk($sformatf("%s_vld%0d", tag, i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("%s_last%0d", tag, i), 32'(bus.last), 32'(i == n - 1));
            chk($sformatf("%s_rdy%0d", tag, i), 32'(bus.ready_out), 32'(i == n - 1));
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out"}, 32'(bus.out), 32'd0);
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_last"}, 32'(bus.last), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.ready_out), 32'd1);
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] l, input logic [3:0] r);
        bus.data_in  = d;
        bus.len_in   = l;
        bus.rep_in   = r;
        bus.valid_in = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.data_in  = '0;
        bus.len_in   = '0;
        bus.rep_in   = '0;
        bus.valid_in = 1'b0;

        @(negedge clk);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_last", 32'(bus.last), 32'd0);
        chk("rst_rdy", 32'(bus.ready_out), 32'd0);
        reset = 1'b1;
        #1;
        chk("rel_rdy", 32'(bus.ready_out), 32'd1);
        @(negedge clk);

        offer(16'h000D, 4'd3, 4'd0);
        bus.valid_in = 1'b0;
        check_stream("single", 64'hD, 4);
        check_idle("single_end");

        offer(16'h000D, 4'd3, 4'd2);
        bus.valid_in = 1'b0;
        check_stream("repeat", 64'hDDD, 12);
        check_idle("repeat_end");

        offer(16'h000D, 4'd3, 4'd0);
        bus.data_in = 16'h000A;
        check_stream("b2b_a", 64'hD, 4);
        bus.valid_in = 1'b0;
        check_stream("b2b_b", 64'hA, 4);
        check_idle("b2b_end");

        offer(16'h0001, 4'd0, 4'd0);
        bus.valid_in = 1'b0;
        check_stream("len0", 64'h1, 1);
        check_idle("len0_end");

        offer(16'hA5C3, 4'd15, 4'd0);
        bus.valid_in = 1'b0;
        check_stream("len15", 64'hA5C3, 16);
        check_idle("len15_end");

        offer(16'hFFF2, 4'd2, 4'd0);
        bus.valid_in = 1'b0;
        check_stream("upper", 64'h2, 3);
        check_idle("upper_end");

        offer(16'h000D, 4'd3, 4'd0);
        bus.data_in = 16'hFFFF;
        bus.len_in  = 4'd7;
        check_stream("hold_a", 64'hD, 4);
        bus.valid_in = 1'b0;
        check_stream("hold_b", 64'hFF, 8);
        check_idle("hold_end");

        offer(16'hA5C3, 4'd15, 4'd1);
        bus.valid_in = 1'b0;
        chk("mid_b1", 32'(bus.out), 32'd1);
        @(negedge clk);
        chk("mid_b2", 32'(bus.out), 32'd0);
        @(negedge clk);
        chk("mid_b3", 32'(bus.out), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_out", 32'(bus.out), 32'd0);
        chk("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_last", 32'(bus.last), 32'd0);
        chk("mid_rst_rdy", 32'(bus.ready_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rdy", 32'(bus.ready_out), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_vld%0d", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("post_out%0d", i), 32'(bus.out), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Parallel-in/serial-out pattern transmitter that produces the single-bit stream consumed by the Mealy sequence detector. It accepts a pattern word of programmable length and repeat count through a valid/ready handshake and shifts it out MSB-first, one bit per clock. Back-to-back words stream without a gap. It is the source end of the serial `in` link: stimulus for the detector in-system and in benches.

## Interface
- `WIDTH`, 16: maximum pattern length in bits. Must be ≥ 2.
- `CNT_W`, 4: width of the repeat-count field.
- `IDLE_BIT`, 0: value driven on `out` when no pattern is being sent.
- `LEN_W`, $clog2(WIDTH): derived. Width of `len_in`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Low clears all state immediately.
- `data_in`  in  WIDTH  pattern word. Bit `len_in` is sent first, bit 0 last.
- `len_in`  in  LEN_W  pattern length minus 1 (0 → 1 bit, WIDTH-1 → WIDTH bits).
- `rep_in`  in  CNT_W  extra repetitions (0 → pattern sent once, N → sent N+1 times).
- `valid_in`  in  1  a word is offered on `data_in`, `len_in` and `rep_in`.
- `ready_out`  out  1  block can accept a word this cycle.
- `out`  out  1  serial bit stream; feeds the detector's `in`.
- `out_valid`  out  1  `out` carries a pattern bit this cycle.
- `last`  out  1  current `out` bit is the final bit of the final repetition.

## Operation
- There are two states: IDLE and SHIFT.
- Acceptance happens at the rising edge where `valid_in && ready_out`.
  - `data_in`, `len_in` and `rep_in` are latched into `shreg`, `len_r` and `rep_r`.
  - `idx` is set to `len_in` and the state becomes SHIFT.
  - The inputs are ignored at all other times, including changes on `data_in` while in SHIFT.
- In SHIFT:
  - `out = shreg[idx]` and `out_valid = 1`.
  - Each edge decrements `idx`.
  - When `idx == 0`:
    - If `rep_r != 0`: decrement `rep_r` and reload `idx = len_r`. The next repetition follows with no gap.
    - Otherwise the word is finished. If a new word is accepted at this same edge, stay in SHIFT with the new word. If not, go to IDLE.
- `last = (state == SHIFT) && (idx == 0) && (rep_r == 0)`.
- `ready_out = reset && ((state == IDLE) || last)`. This gives a one-word lookahead for gapless streaming.
- In IDLE: `out = IDLE_BIT`, `out_valid = 0`, `last = 0`.
- `out`, `out_valid`, `last` and `ready_out` are decoded only from registers (plus `reset`). There is no combinational path from `valid_in` or `data_in` to any output.
- Bits of `data_in` above `len_in` are never transmitted.
- Total bits sent per word = (`len_in` + 1) × (`rep_in` + 1).
  - The largest is WIDTH × 2^CNT_W = 256 at the defaults.
  - `idx` and `rep_r` never wrap below 0.

## Timing
- Reset values, asserted asynchronously while `reset` is low:
  - state IDLE, `shreg = 0`, `idx = 0`, `rep_r = 0`.
  - `out = IDLE_BIT`, `out_valid = 0`, `last = 0`, `ready_out = 0`.
- `ready_out` rises on the first cycle with `reset` high.
- Latency: a word accepted at edge E drives its first bit in the cycle following E.
- The last bit of a word occupies the cycle immediately before the next accepted word's first bit. There are zero idle cycles between words when `valid_in` is held.
- Reset mid-pattern aborts the word immediately: no `last` pulse is produced and no partial repetition resumes after reset.
- `valid_in` high while `ready_out` is low is not an error. The word is simply held off until `ready_out` is high.

## Test plan
- **Single word.** `data_in = 0x000D`, `len_in = 3`, `rep_in = 0`, `valid_in` for one accepting edge.
  - `out` = 1,1,0,1 over 4 cycles, with `out_valid` = 1 for exactly those 4 cycles.
  - `last` is high only on the 4th bit, then `out = 0`.
  - With the detector attached, its `out` pulses on the final 1.
- **Repeat.** Same word with `rep_in = 2`.
  - 12 contiguous bits 1101 1101 1101.
  - `last` is high only on bit 12.
  - `ready_out` is low on bits 1–11.
- **Back-to-back.** `valid_in` held high with word A (0x000D, len 3) then word B (0x000A, len 3).
  - Stream is 1101 1010 with no gap.
  - B is accepted at the edge ending A's `last` cycle.
- **Length extremes.**
  - `len_in = 0`, `data_in = 0x0001` → a single 1 with `last` set in the same cycle.
  - `len_in = 15`, `data_in = 0xA5C3` → 1010 0101 1100 0011.
- **Handshake hold-off.**
  - Change `data_in` to 0xFFFF mid-SHIFT while `valid_in = 1`: the stream is unaffected.
  - The 0xFFFF word is taken only at the next `ready_out`.
- **Reset mid-stream.** Assert `reset` low asynchronously on bit 3 of a 16-bit word.
  - `out` = 0, `out_valid` = 0 and `ready_out` = 0 before the next edge.
  - After release, `ready_out` = 1 and no residual bits are sent.
